// File: rtl/dma_channel_regfile.sv
// Multi-channel DMA base/current address and count registers, programmed byte-serially from the CPU bus.
// Define DMA_REG_READBACK_EN to enable channel and status readback on DB_OUT/DB_OE.
module dma_channel_regfile #(
  parameter int NUM_CH = 4,
  parameter int REG_W  = 16,
  parameter int AW     = $clog2(NUM_CH) + 2
) (
  input  logic                                         CLK,
  input  logic                                         RESET,
  input  logic                                         CS_N,
  input  logic                                         IOR_N,
  input  logic                                         IOW_N,
  input  logic [AW-1:0]                                ADDR,
  input  logic [7:0]                                   DB_IN,
  output logic [7:0]                                   DB_OUT,
  output logic                                         DB_OE,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] xfer_ch,
  input  logic                                         xfer_step,
  output logic [REG_W-1:0]                             cur_addr,
  output logic [REG_W-1:0]                             cur_cnt,
  output logic                                         tc,
  output logic [NUM_CH-1:0]                            tc_status
);

  localparam int unsigned NB  = REG_W / 8;
  localparam int unsigned PW  = $clog2(NB);
  localparam int unsigned CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [REG_W-1:0] base_addr [NUM_CH];
  logic [REG_W-1:0] base_cnt  [NUM_CH];
  logic [REG_W-1:0] curr_addr [NUM_CH];
  logic [REG_W-1:0] curr_cnt  [NUM_CH];
  logic [NUM_CH-1:0] autoinit;
  logic [NUM_CH-1:0] decr;
  logic [PW-1:0]     ptr;
  logic              iow_q;

  logic              wr_acc;
  logic              ctrl_sel;
  logic [AW-1:0]     addr_shr;
  logic [CHW-1:0]    sel_ch;
  logic              sel_valid;
  logic [AW-2:0]     ofs;
  logic              chan_wr;
  logic              ptr_clr;
  logic              mclr;
  logic              mode_wr;
  logic              clr;
  logic              ptr_adv;
  logic              stat_clr;
  logic              xfer_valid;
  logic [CHW-1:0]    xidx;
  logic              step_valid;
  logic              step_tc;
  logic [NUM_CH-1:0] tc_set;

  function automatic logic [REG_W-1:0] put_byte(input logic [REG_W-1:0] v,
                                                input logic [PW-1:0] p,
                                                input logic [7:0] b);
    logic [REG_W-1:0] r;
    r = v;
    for (int unsigned i = 0; i < NB; i++) begin
      if (p == PW'(i)) r[8*i +: 8] = b;
    end
    return r;
  endfunction

  always_comb begin
    wr_acc    = !CS_N && !IOW_N && iow_q;
    ctrl_sel  = ADDR[AW-1];
    addr_shr  = ADDR >> 1;
    sel_ch    = addr_shr[CHW-1:0];
    sel_valid = int'(sel_ch) < NUM_CH;
    ofs       = ADDR[AW-2:0];
    chan_wr   = wr_acc && !ctrl_sel && sel_valid;
    ptr_clr   = wr_acc && ctrl_sel && (int'(ofs) == 0);
    mclr      = wr_acc && ctrl_sel && (int'(ofs) == 1);
    mode_wr   = wr_acc && ctrl_sel && (int'(ofs) == 2) && (int'(DB_IN[2:0]) < NUM_CH);
    clr       = RESET || mclr;
  end

  // A CPU write to the serviced channel takes priority; the coinciding step is dropped outright.
  always_comb begin
    xfer_valid = int'(xfer_ch) < NUM_CH;
    xidx       = xfer_valid ? xfer_ch : '0;
    step_valid = xfer_step && xfer_valid && !(chan_wr && (sel_ch == xfer_ch));
    step_tc    = step_valid && (curr_cnt[xidx] == '0);
    tc_set     = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (step_tc && (xidx == CHW'(c))) tc_set[c] = 1'b1;
    end
    cur_addr = xfer_valid ? curr_addr[xidx] : '0;
    cur_cnt  = xfer_valid ? curr_cnt[xidx]  : '0;
  end

`ifdef DMA_REG_READBACK_EN
  logic           ior_q;
  logic           rd_acc;
  logic           chan_rd;
  logic           stat_rd;
  logic [CHW-1:0] sel_idx;

  function automatic logic [7:0] get_byte(input logic [REG_W-1:0] v, input logic [PW-1:0] p);
    logic [7:0] r;
    r = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      if (p == PW'(i)) r = v[8*i +: 8];
    end
    return r;
  endfunction

  always_comb begin
    rd_acc   = !CS_N && !IOR_N && ior_q && !wr_acc;
    chan_rd  = rd_acc && !ctrl_sel && sel_valid;
    stat_rd  = rd_acc && ctrl_sel && (int'(ofs) == 3);
    sel_idx  = sel_valid ? sel_ch : '0;
    ptr_adv  = chan_wr || chan_rd;
    stat_clr = stat_rd;
  end

  always_ff @(posedge CLK) begin
    if (clr) begin
      ior_q  <= 1'b1;
      DB_OUT <= '0;
      DB_OE  <= 1'b0;
    end else begin
      ior_q <= IOR_N;
      DB_OE <= !CS_N && !IOR_N;
      if (stat_rd) begin
        DB_OUT <= 8'(tc_status);
      end else if (chan_rd) begin
        DB_OUT <= get_byte(ADDR[0] ? curr_cnt[sel_idx] : curr_addr[sel_idx], ptr);
      end
    end
  end
`else
  logic unused_ior;

  assign unused_ior = IOR_N;
  assign ptr_adv    = chan_wr;
  assign stat_clr   = 1'b0;
  assign DB_OUT     = '0;
  assign DB_OE      = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (clr) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        base_addr[c] <= '0;
        base_cnt[c]  <= '0;
        curr_addr[c] <= '0;
        curr_cnt[c]  <= '0;
      end
      autoinit  <= '0;
      decr      <= '0;
      ptr       <= '0;
      tc        <= 1'b0;
      tc_status <= '0;
      iow_q     <= 1'b1;
    end else begin
      iow_q <= IOW_N;
      tc    <= step_tc;
      // Flags raised this cycle survive a coinciding status-read clear.
      tc_status <= (stat_clr ? '0 : tc_status) | tc_set;

      if (ptr_clr) begin
        ptr <= '0;
      end else if (ptr_adv) begin
        ptr <= (ptr == PW'(NB - 1)) ? '0 : ptr + 1'b1;
      end

      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (chan_wr && (sel_ch == CHW'(c))) begin
          if (ADDR[0]) begin
            base_cnt[c] <= put_byte(base_cnt[c], ptr, DB_IN);
            curr_cnt[c] <= put_byte(curr_cnt[c], ptr, DB_IN);
          end else begin
            base_addr[c] <= put_byte(base_addr[c], ptr, DB_IN);
            curr_addr[c] <= put_byte(curr_addr[c], ptr, DB_IN);
          end
        end else if (step_valid && (xidx == CHW'(c))) begin
          if (step_tc && autoinit[c]) begin
            curr_addr[c] <= base_addr[c];
            curr_cnt[c]  <= base_cnt[c];
          end else begin
            curr_addr[c] <= decr[c] ? curr_addr[c] - 1'b1 : curr_addr[c] + 1'b1;
            curr_cnt[c]  <= curr_cnt[c] - 1'b1;
          end
        end
        if (mode_wr && (DB_IN[2:0] == 3'(c))) begin
          autoinit[c] <= DB_IN[4];
          decr[c]     <= DB_IN[5];
        end
      end
    end
  end

endmodule

// File: tb/tb_dma_channel_regfile.sv
// Directed bench for dma_channel_regfile (NUM_CH=4, REG_W=16); expectations track DMA_REG_READBACK_EN.
module tb_dma_channel_regfile;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        CS_N = 1'b1;
  logic        IOR_N = 1'b1;
  logic        IOW_N = 1'b1;
  logic [3:0]  ADDR = '0;
  logic [7:0]  DB_IN = '0;
  logic [7:0]  DB_OUT;
  logic        DB_OE;
  logic [1:0]  xfer_ch = '0;
  logic        xfer_step = 1'b0;
  logic [15:0] cur_addr;
  logic [15:0] cur_cnt;
  logic        tc;
  logic [3:0]  tc_status;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef DMA_REG_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  always #5 CLK = ~CLK;

  dma_channel_regfile #(.NUM_CH(4), .REG_W(16)) dut (
    .CLK(CLK), .RESET(RESET), .CS_N(CS_N), .IOR_N(IOR_N), .IOW_N(IOW_N),
    .ADDR(ADDR), .DB_IN(DB_IN), .DB_OUT(DB_OUT), .DB_OE(DB_OE),
    .xfer_ch(xfer_ch), .xfer_step(xfer_step), .cur_addr(cur_addr),
    .cur_cnt(cur_cnt), .tc(tc), .tc_status(tc_status)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cpu_wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge CLK);
    CS_N = 1'b0; ADDR = a; DB_IN = d; IOW_N = 1'b0;
    @(negedge CLK);
    IOW_N = 1'b1; CS_N = 1'b1;
  endtask

  task automatic cpu_rd(input logic [3:0] a, output logic [7:0] d, output logic oe);
    @(negedge CLK);
    CS_N = 1'b0; ADDR = a; IOR_N = 1'b0;
    @(negedge CLK);
    d = DB_OUT; oe = DB_OE;
    IOR_N = 1'b1; CS_N = 1'b1;
  endtask

  task automatic step(input logic [1:0] ch);
    @(negedge CLK);
    xfer_ch = ch; xfer_step = 1'b1;
    @(negedge CLK);
    xfer_step = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_addr"}, 32'(cur_addr), 32'h0);
    chk({tag, "_cnt"},  32'(cur_cnt),  32'h0);
    chk({tag, "_tc"},   32'(tc),       32'h0);
    chk({tag, "_stat"}, 32'(tc_status), 32'h0);
    chk({tag, "_dbout"}, 32'(DB_OUT),  32'h0);
    chk({tag, "_dboe"}, 32'(DB_OE),    32'h0);
  endtask

  logic [7:0] rd;
  logic       oe;

  initial begin
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    xfer_ch = 2'd1;
    chk_all_zero("reset");

    // Two-byte address write on ch1, low byte first.
    cpu_wr(4'd2, 8'h88);
    chk("addr_lo", 32'(cur_addr), 32'h0088);
    cpu_wr(4'd2, 8'hCC);
    chk("addr_full", 32'(cur_addr), 32'hCC88);

    // Strobe held low three cycles: one access only.
    @(negedge CLK);
    CS_N = 1'b0; ADDR = 4'd3; DB_IN = 8'h02; IOW_N = 1'b0;
    repeat (3) @(negedge CLK);
    IOW_N = 1'b1; CS_N = 1'b1;
    chk("hold_one_byte", 32'(cur_cnt), 32'h0002);
    cpu_wr(4'd3, 8'h00);
    chk("cnt_full", 32'(cur_cnt), 32'h0002);

    // Mode ch1 increment, three back-to-back steps.
    cpu_wr(4'd10, 8'h01);
    @(negedge CLK);
    xfer_ch = 2'd1; xfer_step = 1'b1;
    @(negedge CLK);
    chk("s1_addr", 32'(cur_addr), 32'hCC89);
    chk("s1_cnt", 32'(cur_cnt), 32'h0001);
    chk("s1_tc", 32'(tc), 32'h0);
    @(negedge CLK);
    chk("s2_addr", 32'(cur_addr), 32'hCC8A);
    chk("s2_cnt", 32'(cur_cnt), 32'h0000);
    chk("s2_tc", 32'(tc), 32'h0);
    @(negedge CLK);
    xfer_step = 1'b0;
    chk("s3_addr", 32'(cur_addr), 32'hCC8B);
    chk("s3_cnt", 32'(cur_cnt), 32'hFFFF);
    chk("s3_tc", 32'(tc), 32'h1);
    chk("s3_stat", 32'(tc_status), 32'h2);
    @(negedge CLK);
    chk("tc_pulse_end", 32'(tc), 32'h0);

    // Status read and clear.
    cpu_rd(4'd11, rd, oe);
    chk("stat_rd1", 32'(rd), RB ? 32'h02 : 32'h00);
    chk("stat_oe", 32'(oe), RB ? 32'h1 : 32'h0);
    chk("stat_after1", 32'(tc_status), RB ? 32'h0 : 32'h2);
    cpu_rd(4'd11, rd, oe);
    chk("stat_rd2", 32'(rd), 32'h00);
    @(negedge CLK);
    chk("oe_release", 32'(DB_OE), 32'h0);

    // Ch2 autoinit decrement from zero count.
    cpu_wr(4'd10, 8'h32);
    cpu_wr(4'd4, 8'h00); cpu_wr(4'd4, 8'h00);
    cpu_wr(4'd5, 8'h00); cpu_wr(4'd5, 8'h00);
    step(2'd2);
    chk("ai_tc", 32'(tc), 32'h1);
    chk("ai_addr", 32'(cur_addr), 32'h0000);
    chk("ai_cnt", 32'(cur_cnt), 32'h0000);
    chk("ai_stat", 32'(tc_status), RB ? 32'h4 : 32'h6);
    cpu_wr(4'd10, 8'h22);
    step(2'd2);
    chk("noai_tc", 32'(tc), 32'h1);
    chk("noai_addr", 32'(cur_addr), 32'hFFFF);
    chk("noai_cnt", 32'(cur_cnt), 32'hFFFF);

    // Master clear, then pointer clear between bytes.
    cpu_wr(4'd9, 8'h00);
    chk_all_zero("mclr");
    cpu_wr(4'd4, 8'h11);
    cpu_wr(4'd8, 8'h00);
    cpu_wr(4'd4, 8'h22);
    chk("ptr_clr_addr", 32'(cur_addr), 32'h0022);
    cpu_wr(4'd8, 8'h00);
    cpu_rd(4'd4, rd, oe);
    chk("rdback_lo", 32'(rd), RB ? 32'h22 : 32'h00);
    cpu_rd(4'd4, rd, oe);
    chk("rdback_hi", 32'(rd), 32'h00);
    cpu_wr(4'd8, 8'h00);
    cpu_rd(4'd4, rd, oe);
    chk("rdback_lo2", 32'(rd), RB ? 32'h22 : 32'h00);
    cpu_wr(4'd4, 8'h55);
    chk("rd_ptr_adv", 32'(cur_addr), RB ? 32'h5522 : 32'h0055);

    // Same-cycle write and step on ch0.
    cpu_wr(4'd8, 8'h00);
    @(negedge CLK);
    CS_N = 1'b0; ADDR = 4'd0; DB_IN = 8'h5A; IOW_N = 1'b0;
    xfer_ch = 2'd0; xfer_step = 1'b1;
    @(negedge CLK);
    IOW_N = 1'b1; CS_N = 1'b1; xfer_step = 1'b0;
    chk("coll_addr", 32'(cur_addr), 32'h005A);
    chk("coll_cnt", 32'(cur_cnt), 32'h0000);
    chk("coll_tc", 32'(tc), 32'h0);
    step(2'd0);
    chk("ch0_step_addr", 32'(cur_addr), 32'h005B);
    chk("ch0_step_tc", 32'(tc), 32'h1);
    chk("ch0_step_stat", 32'(tc_status), 32'h1);

    // Reset in the middle of a two-byte write.
    cpu_wr(4'd8, 8'h00);
    cpu_wr(4'd0, 8'hAB);
    chk("pre_rst_addr", 32'(cur_addr), 32'h00AB);
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    chk_all_zero("mid_rst");
    cpu_wr(4'd0, 8'hCD);
    chk("post_rst_lo", 32'(cur_addr), 32'h00CD);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
